addsub_accum: RTL

Parametrised, registered add/subtract unit with a running accumulator, for the datapath labs.
- Performs WIDTH-bit add or subtract on two operands, or adds/subtracts an operand into an internal accumulator.
- Flags carry/borrow, signed overflow and zero; optional signed saturation.
- Valid/ready handshake on both input and output; one-deep registered output stage.

---
 rtl/addsub_pkg.sv | 11 +
 rtl/addsub_core.sv | 47 ++++
 rtl/addsub_accum.sv | 102 ++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types for the add/subtract accumulator datapath.
package addsub_pkg;

  typedef enum logic [1:0] {
    MODE_ADD     = 2'd0,
    MODE_SUB     = 2'd1,
    MODE_ACC_ADD = 2'd2,
    MODE_ACC_SUB = 2'd3
  } mode_t;

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit add/subtract with carry/borrow, signed overflow, zero and optional
// signed saturation.
module addsub_core #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SATURATE = 0
) (
  input  logic [WIDTH-1:0] l_i,
  input  logic [WIDTH-1:0] r_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] res_o,
  output logic             cbout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] r_eff;
  logic [WIDTH:0]   raw;
  logic             sign_l;
  logic             sign_r;
  logic             sign_raw;

  always_comb begin
    r_eff    = sub_i ? ~r_i : r_i;
    raw      = {1'b0, l_i} + {1'b0, r_eff} + {{WIDTH{1'b0}}, sub_i};
    sign_l   = l_i[WIDTH-1];
    sign_r   = r_i[WIDTH-1];
    sign_raw = raw[WIDTH-1];

    // Subtract reports borrow, which is the inverted carry of L + ~R + 1.
    cbout_o = sub_i ? ~raw[WIDTH] : raw[WIDTH];

    if (sub_i) begin
      ovf_o = (sign_l != sign_r) && (sign_raw != sign_l);
    end else begin
      ovf_o = (sign_l == sign_r) && (sign_raw != sign_l);
    end

    if ((SATURATE != 0) && ovf_o) begin
      res_o = sign_l ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res_o = raw[WIDTH-1:0];
    end

    zero_o = (res_o == '0);
  end

endmodule

// File: rtl/addsub_accum.sv
// Registered add/subtract unit with running accumulator and valid/ready handshakes on both sides.
module addsub_accum
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cbout,
  output logic             ovf,
  output logic             zero,
  output logic [WIDTH-1:0] acc
);

  mode_t            mode_e;
  logic             acc_sel;
  logic             sub_sel;
  logic             accept;
  logic [WIDTH-1:0] l_op;
  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] res;
  logic             res_cb;
  logic             res_ovf;
  logic             res_zero;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cbout_q;
  logic             ovf_q;
  logic             zero_q;
  logic [WIDTH-1:0] acc_q;

  always_comb begin
    mode_e   = mode_t'(mode);
    acc_sel  = (mode_e == MODE_ACC_ADD) || (mode_e == MODE_ACC_SUB);
    sub_sel  = (mode_e == MODE_SUB) || (mode_e == MODE_ACC_SUB);
    // clr blocks acceptance so an accumulator load never races the clear.
    in_ready = !clr && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;
    l_op     = acc_sel ? acc_q : a;
    r_op     = acc_sel ? a : b;
  end

  addsub_core #(
    .WIDTH   (WIDTH),
    .SATURATE(SATURATE)
  ) u_core (
    .l_i    (l_op),
    .r_i    (r_op),
    .sub_i  (sub_sel),
    .res_o  (res),
    .cbout_o(res_cb),
    .ovf_o  (res_ovf),
    .zero_o (res_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cbout_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      sum_q       <= res;
      cbout_q     <= res_cb;
      ovf_q       <= res_ovf;
      zero_q      <= res_zero;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (accept && acc_sel) begin
      acc_q <= res;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cbout     = cbout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign acc       = acc_q;

endmodule
